// File: rtl/pipe_reg_chain.sv
// ---------------------------------------------------------------------------
// pipe_reg_chain
//
// Chain of DEPTH registers, each WIDTH bits wide, with a per-stage valid bit
// and valid/ready flow control. Empty stages collapse: when the output stalls,
// upstream words keep advancing into empty downstream stages, so bubbles are
// squeezed out. Used for retiming / latency matching between blocks.
//
// Parameters:
//   WIDTH      data width in bits (>=1)
//   DEPTH      number of register stages (>=1)
//   RESET_VAL  value loaded into every data stage on reset or flush
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous flush, active-high (priority over all traffic)
//   in_valid   producer has data
//   in_ready   chain accepts in_data this cycle
//   in_data    input word
//   out_valid  out_data is valid
//   out_ready  consumer accepts out_data
//   out_data   output word (last stage's data register)
//   count      number of valid stages, 0..DEPTH
//   stall_cnt  (PIPE_REG_CHAIN_STATS_EN only) saturating count of cycles
//              with a valid output word held back by out_ready=0
//
// Optional feature macro: PIPE_REG_CHAIN_STATS_EN
// ---------------------------------------------------------------------------
module pipe_reg_chain #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef PIPE_REG_CHAIN_STATS_EN
  ,
  output logic [15:0]                stall_cnt
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;

  // Per-stage ready and the word presented to each stage from upstream.
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] up_valid;
  logic [WIDTH-1:0] up_data [DEPTH];
  logic             push, pop;

  // Ready ripples from the output back to the input: a stage can take a new
  // word if it is empty or if the stage after it is moving.
  always_comb begin
    logic r;
    // NOTE: combinational logic uses blocking '=' so each loop iteration sees
    // the value just computed; sequential state below uses '<=' only.
    r   = out_ready;
    rdy = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      r      = ~valid_q[i] | r;
      rdy[i] = r;
    end
  end

  always_comb begin
    up_valid[0] = in_valid;
    up_data[0]  = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      up_valid[i] = valid_q[i-1];
      up_data[i]  = data_q[i-1];
    end
  end

  assign in_ready  = rdy[0] & ~clr;
  assign out_valid = valid_q[DEPTH-1] & ~clr;
  assign out_data  = data_q[DEPTH-1];
  assign count     = count_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    // NOTE: every output of this block gets a hold value first, so no path
    // leaves a variable unassigned and no latch is inferred.
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i];
      data_d[i]  = data_q[i];
      if (clr) begin
        valid_d[i] = 1'b0;
        data_d[i]  = RESET_VAL;
      end else if (rdy[i]) begin
        valid_d[i] = up_valid[i];
        // Data only moves with a valid word, so an empty output stage keeps
        // showing the last word that reached it.
        if (up_valid[i]) begin
          data_d[i] = up_data[i];
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      count_q <= '0;
      // NOTE: the data array is reset too, because out_data must read
      // RESET_VAL straight after reset even though no word is valid.
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VAL;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

`ifdef PIPE_REG_CHAIN_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clr) begin
      stall_cnt_d = '0;
    end else if (valid_q[DEPTH-1] && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// ---------------------------------------------------------------------------
// tb_pipe_reg_chain
//
// Self-checking bench for pipe_reg_chain (WIDTH=8, DEPTH=4). A transaction
// level model keeps the words in the chain as a queue stamped with their
// acceptance cycle: the oldest word has nothing ahead of it, so it is at the
// output DEPTH cycles after acceptance; occupancy is the queue size; the chain
// can take a word when it has a free slot or the output is draining.
// Define PIPE_REG_CHAIN_STATS_EN to also exercise stall_cnt.
// ---------------------------------------------------------------------------
module tb_pipe_reg_chain;

  localparam int               WIDTH     = 8;
  localparam int               DEPTH     = 4;
  localparam int               CW        = $clog2(DEPTH + 1);
  localparam logic [WIDTH-1:0] RESET_VAL = '0;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
`ifdef PIPE_REG_CHAIN_STATS_EN
  logic [15:0]      stall_cnt;
`endif

  pipe_reg_chain #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
`ifdef PIPE_REG_CHAIN_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model
  typedef struct {
    logic [WIDTH-1:0] data;
    int               acc;
  } word_t;

  word_t            mq[$];
  int               cyc;
  logic [WIDTH-1:0] last_out;
  int               stall_model;

  int n_checks = 0;
  int n_errors = 0;

  // Values observed during the most recent step
  logic             s_in_ready;
  logic             s_out_valid;
  logic [WIDTH-1:0] s_out_data;
  logic [CW-1:0]    s_count;
  int               s_stall;

  function automatic void model_reset();
    mq.delete();
    last_out    = RESET_VAL;
    stall_model = 0;
  endfunction

  // One clock cycle: drive inputs after the falling edge, compare every output
  // against the model, then advance the model across the rising edge.
  task automatic step(input logic iv, input logic [WIDTH-1:0] id,
                      input logic ordy, input logic iclr);
    logic             arrived;
    logic             e_in_ready;
    logic             e_out_valid;
    logic [WIDTH-1:0] e_out_data;
    logic             do_push;
    logic             do_pop;
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    clr       = iclr;
    #1;
    arrived = 1'b0;
    if (mq.size() > 0) arrived = (cyc >= mq[0].acc + DEPTH);
    e_in_ready  = !iclr && ((mq.size() < DEPTH) || ordy);
    e_out_valid = arrived && !iclr;
    e_out_data  = arrived ? mq[0].data : last_out;

    n_checks++;
    if (in_ready !== e_in_ready) begin
      n_errors++;
      $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, e_in_ready);
    end
    n_checks++;
    if (out_valid !== e_out_valid) begin
      n_errors++;
      $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, e_out_valid);
    end
    n_checks++;
    if (out_data !== e_out_data) begin
      n_errors++;
      $display("FAIL out_data cyc=%0d got=%h exp=%h", cyc, out_data, e_out_data);
    end
    n_checks++;
    if (count !== CW'(mq.size())) begin
      n_errors++;
      $display("FAIL count cyc=%0d got=%0d exp=%0d", cyc, count, mq.size());
    end
`ifdef PIPE_REG_CHAIN_STATS_EN
    n_checks++;
    if (stall_cnt !== 16'(stall_model)) begin
      n_errors++;
      $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, stall_model);
    end
    s_stall = int'(stall_cnt);
`else
    s_stall = 0;
`endif
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_out_data  = out_data;
    s_count     = count;

    do_push = iv && e_in_ready;
    do_pop  = e_out_valid && ordy;
    @(posedge clk);
    if (iclr) begin
      model_reset();
    end else begin
      if (arrived) last_out = mq[0].data;
      if (arrived && !ordy && stall_model < 65535) stall_model++;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{data: id, acc: cyc});
    end
    cyc++;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #2;
    n_checks++;
    if (out_valid !== 1'b0 || count !== '0 || out_data !== RESET_VAL || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_state got v=%b c=%0d d=%h r=%b exp v=0 c=0 d=%h r=1",
               out_valid, count, out_data, in_ready, RESET_VAL);
    end
    #13;
    rst_n = 1'b1;
    model_reset();
    cyc = 0;
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] w [4];
    logic [WIDTH-1:0] got[$];
    int acc0, first_seen, peak, c, accepted;
    w = '{8'h12, 8'h34, 8'h56, 8'h78};
    first_seen = -1;
    peak = 0;
    accepted = 0;
    acc0 = cyc;
    for (int k = 0; k < 4; k++) begin
      c = cyc;
      step(1'b1, w[k], 1'b1, 1'b0);
      if (s_in_ready) accepted++;
      if (int'(s_count) > peak) peak = int'(s_count);
      if (s_out_valid) begin
        got.push_back(s_out_data);
        if (first_seen < 0) first_seen = c;
      end
    end
    for (int t = 0; t < 20 && got.size() < 4; t++) begin
      c = cyc;
      step(1'b0, '0, 1'b1, 1'b0);
      if (int'(s_count) > peak) peak = int'(s_count);
      if (s_out_valid) begin
        got.push_back(s_out_data);
        if (first_seen < 0) first_seen = c;
      end
    end
    n_checks++;
    if (accepted != 4) begin
      n_errors++;
      $display("FAIL b2b_accepts got=%0d exp=4", accepted);
    end
    n_checks++;
    if (got.size() != 4) begin
      n_errors++;
      $display("FAIL b2b_drain_timeout got=%0d words exp=4", got.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (got[k] !== w[k]) begin
          n_errors++;
          $display("FAIL b2b_order idx=%0d got=%h exp=%h", k, got[k], w[k]);
        end
      end
    end
    n_checks++;
    if (first_seen - acc0 != DEPTH) begin
      n_errors++;
      $display("FAIL b2b_latency got=%0d exp=%0d", first_seen - acc0, DEPTH);
    end
    n_checks++;
    if (peak != 4) begin
      n_errors++;
      $display("FAIL b2b_peak_count got=%0d exp=4", peak);
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] w [6];
    logic [WIDTH-1:0] got[$];
    int idx;
    for (int k = 0; k < 6; k++) w[k] = WIDTH'($urandom);
    idx = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, w[idx], 1'b0, 1'b0);
      if (s_in_ready) idx++;
    end
    n_checks++;
    if (idx != 4 || s_in_ready !== 1'b0 || s_count !== CW'(4) || s_out_data !== w[0]) begin
      n_errors++;
      $display("FAIL bp_full got acc=%0d r=%b c=%0d d=%h exp acc=4 r=0 c=4 d=%h",
               idx, s_in_ready, s_count, s_out_data, w[0]);
    end
    for (int t = 0; t < 30 && got.size() < 6; t++) begin
      step(idx < 6, (idx < 6) ? w[idx] : '0, 1'b1, 1'b0);
      if (s_out_valid) got.push_back(s_out_data);
      if (s_in_ready && idx < 6) idx++;
    end
    n_checks++;
    if (got.size() != 6) begin
      n_errors++;
      $display("FAIL bp_drain_timeout got=%0d words exp=6", got.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_checks++;
        if (got[k] !== w[k]) begin
          n_errors++;
          $display("FAIL bp_order idx=%0d got=%h exp=%h", k, got[k], w[k]);
        end
      end
    end
  endtask

  task automatic test_bubble();
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 8'hA2, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if (s_count !== CW'(2) || s_out_data !== 8'hA1 || s_out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL bubble_stall got c=%0d d=%h v=%b exp c=2 d=a1 v=1",
               s_count, s_out_data, s_out_valid);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (s_out_valid !== 1'b1 || s_out_data !== 8'hA1) begin
      n_errors++;
      $display("FAIL bubble_first got v=%b d=%h exp v=1 d=a1", s_out_valid, s_out_data);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (s_out_valid !== 1'b1 || s_out_data !== 8'hA2) begin
      n_errors++;
      $display("FAIL bubble_second got v=%b d=%h exp v=1 d=a2", s_out_valid, s_out_data);
    end
  endtask

  task automatic test_async_reset();
    logic [WIDTH-1:0] got[$];
    step(1'b1, 8'h21, 1'b1, 1'b0);
    step(1'b1, 8'h22, 1'b1, 1'b0);
    step(1'b1, 8'h23, 1'b1, 1'b0);
    // Now just past a rising edge with three words in flight.
    #3;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || count !== '0 || out_data !== RESET_VAL || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL async_reset got v=%b c=%0d d=%h r=%b exp v=0 c=0 d=%h r=1",
               out_valid, count, out_data, in_ready, RESET_VAL);
    end
    model_reset();
    #6;
    rst_n = 1'b1;
    step(1'b1, 8'h56, 1'b1, 1'b0);
    step(1'b1, 8'h78, 1'b1, 1'b0);
    for (int t = 0; t < 20 && got.size() < 2; t++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      if (s_out_valid) got.push_back(s_out_data);
    end
    n_checks++;
    if (got.size() != 2) begin
      n_errors++;
      $display("FAIL rst_after_timeout got=%0d words exp=2", got.size());
    end else if (got[0] !== 8'h56 || got[1] !== 8'h78) begin
      n_errors++;
      $display("FAIL rst_after_order got=%h,%h exp=56,78", got[0], got[1]);
    end
  endtask

  task automatic test_flush();
    int acc, seen, c;
    for (int k = 0; k < 4; k++) step(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b1);
    n_checks++;
    if (s_in_ready !== 1'b0 || s_out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_gate got r=%b v=%b exp r=0 v=0", s_in_ready, s_out_valid);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (s_count !== '0 || s_out_valid !== 1'b0 || s_out_data !== RESET_VAL) begin
      n_errors++;
      $display("FAIL flush_after got c=%0d v=%b d=%h exp c=0 v=0 d=%h",
               s_count, s_out_valid, s_out_data, RESET_VAL);
    end
    acc = cyc;
    step(1'b1, 8'hC3, 1'b1, 1'b0);
    seen = -1;
    for (int t = 0; t < 20 && seen < 0; t++) begin
      c = cyc;
      step(1'b0, '0, 1'b1, 1'b0);
      if (s_out_valid && s_out_data === 8'hC3) seen = c;
    end
    n_checks++;
    if (seen - acc != DEPTH) begin
      n_errors++;
      $display("FAIL flush_latency got=%0d exp=%0d", seen - acc, DEPTH);
    end
  endtask

`ifdef PIPE_REG_CHAIN_STATS_EN
  task automatic test_stall_stats();
    int waited;
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 8'h5C, 1'b0, 1'b0);
    waited = 0;
    while (!s_out_valid && waited < 20) begin
      step(1'b0, '0, 1'b0, 1'b0);
      waited++;
    end
    for (int k = 0; k < 9; k++) step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if (s_stall != 10) begin
      n_errors++;
      $display("FAIL stall_count got=%0d exp=10", s_stall);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (s_stall != 0) begin
      n_errors++;
      $display("FAIL stall_clear got=%0d exp=0", s_stall);
    end
  endtask
`endif

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      step(($urandom % 4) != 0, WIDTH'($urandom),
           ($urandom % 3) != 0, ($urandom % 40) == 0);
    end
    for (int t = 0; t < 20; t++) step(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (s_count !== '0 || mq.size() != 0) begin
      n_errors++;
      $display("FAIL random_drain got c=%0d model=%0d exp 0", s_count, mq.size());
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_bubble();
    test_async_reset();
    test_flush();
`ifdef PIPE_REG_CHAIN_STATS_EN
    test_stall_stats();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
